vga_grid_renderer: RTL



---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_timing_gen.sv | 49 ++++
 rtl/vga_grid_renderer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and pixel colour type for the Tetris display path.
package vga_pkg;

  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FP      = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BP      = 10'd48;
  localparam logic [9:0] H_TOTAL   = 10'd800;

  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FP      = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BP      = 10'd33;
  localparam logic [9:0] V_TOTAL   = 10'd525;

  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FP;
  localparam logic [9:0] H_SYNC_END   = H_VISIBLE + H_FP + H_SYNC;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FP;
  localparam logic [9:0] V_SYNC_END   = V_VISIBLE + V_FP + V_SYNC;

  localparam int GRID_DIM = 16;

  typedef logic [11:0] rgb12_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider, h/v raster counters and raw (undelayed) syncs / visible flag.
module vga_timing_gen
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       visible,
  output logic       hsync_raw,
  output logic       vsync_raw
);

  logic [1:0] div_r;
  logic [9:0] h_r;
  logic [9:0] v_r;

  // Divider and raster counters; h/v only move on the pixel enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r <= 2'd0;
      h_r   <= 10'd0;
      v_r   <= 10'd0;
    end else begin
      div_r <= div_r + 2'd1;
      if (pix_en) begin
        if (h_r == H_TOTAL - 10'd1) begin
          h_r <= 10'd0;
          if (v_r == V_TOTAL - 10'd1) begin
            v_r <= 10'd0;
          end else begin
            v_r <= v_r + 10'd1;
          end
        end else begin
          h_r <= h_r + 10'd1;
        end
      end
    end
  end

  assign pix_en    = (div_r == 2'd3);
  assign h         = h_r;
  assign v         = v_r;
  assign visible   = (h_r < H_VISIBLE) && (v_r < V_VISIBLE);
  assign hsync_raw = !((h_r >= H_SYNC_START) && (h_r < H_SYNC_END));
  assign vsync_raw = !((v_r >= V_SYNC_START) && (v_r < V_SYNC_END));

endmodule

// File: rtl/vga_grid_renderer.sv
// 16x16 playfield renderer: per-frame grid snapshot, divider-free cell indexing, 2-tick pixel pipeline.
// Optional build macro GRID_LINES_EN draws a 1-pixel grey border on every cell.
module vga_grid_renderer
  import vga_pkg::*;
#(
  parameter int     CELL_PX   = 24,
  parameter int     BOARD_X0  = 128,
  parameter int     BOARD_Y0  = 48,
  parameter rgb12_t FILL_RGB  = 12'hF80,
  parameter rgb12_t EMPTY_RGB = 12'h111,
  parameter rgb12_t BG_RGB    = 12'h000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] grid_in,
  output logic         hsync,
  output logic         vsync,
  output logic [11:0]  rgb,
  output logic         frame_start
);

  localparam int BOARD_PX = GRID_DIM * CELL_PX;
  localparam int SXW      = $clog2(CELL_PX + 1);
  localparam int CW       = $clog2(GRID_DIM);
  localparam logic [9:0]     BX0    = 10'(BOARD_X0);
  localparam logic [9:0]     BX1    = 10'(BOARD_X0 + BOARD_PX);
  localparam logic [9:0]     BY0    = 10'(BOARD_Y0);
  localparam logic [9:0]     BY1    = 10'(BOARD_Y0 + BOARD_PX);
  localparam logic [SXW-1:0] S_LAST = SXW'(CELL_PX - 1);
`ifdef GRID_LINES_EN
  localparam rgb12_t LINE_RGB = 12'h444;
`endif

  if ((BOARD_X0 + BOARD_PX > int'(H_VISIBLE)) || (BOARD_Y0 + BOARD_PX > int'(V_VISIBLE))) begin : g_board_fit
    $error("vga_grid_renderer: board does not fit the visible screen");
  end

  logic           pix_en_s, visible_s, hsync_raw_s, vsync_raw_s;
  logic [9:0]     h_s, v_s;
  logic           in_x_s, in_y_s, snap_now_s;
  logic [SXW-1:0] sx_r, sy_r, cur_sx_s, cur_sy_s;
  logic [CW-1:0]  cx_r, cy_r, cur_cx_s, cur_cy_s;
  logic [255:0]   snap_r;
  logic           frame_start_r;
  logic           in_board_s1_r, visible_s1_r, hsync_s1_r, vsync_s1_r;
  logic [CW-1:0]  cx_s1_r, cy_s1_r;
  rgb12_t         rgb_next_s, rgb_r;
  logic           hsync_r, vsync_r;
`ifdef GRID_LINES_EN
  logic           border_s1_r;
`endif

  vga_timing_gen u_timing (
    .clk       (clk),
    .reset     (reset),
    .pix_en    (pix_en_s),
    .h         (h_s),
    .v         (v_s),
    .visible   (visible_s),
    .hsync_raw (hsync_raw_s),
    .vsync_raw (vsync_raw_s)
  );

  // Counters restart on the board's first column/row, so the current value is overridden there.
  assign in_x_s     = (h_s >= BX0) && (h_s < BX1);
  assign in_y_s     = (v_s >= BY0) && (v_s < BY1);
  assign cur_sx_s   = (h_s == BX0) ? {SXW{1'b0}} : sx_r;
  assign cur_cx_s   = (h_s == BX0) ? {CW{1'b0}}  : cx_r;
  assign cur_sy_s   = (v_s == BY0) ? {SXW{1'b0}} : sy_r;
  assign cur_cy_s   = (v_s == BY0) ? {CW{1'b0}}  : cy_r;
  assign snap_now_s = pix_en_s && (h_s == 10'd0) && (v_s == V_VISIBLE);

  // Sub-pixel / cell counters; vertical ones step once per line at the last column.
  always_ff @(posedge clk) begin
    if (reset) begin
      sx_r <= '0;
      cx_r <= '0;
      sy_r <= '0;
      cy_r <= '0;
    end else if (pix_en_s) begin
      if (in_x_s) begin
        if (cur_sx_s == S_LAST) begin
          sx_r <= '0;
          cx_r <= cur_cx_s + CW'(1);
        end else begin
          sx_r <= cur_sx_s + SXW'(1);
          cx_r <= cur_cx_s;
        end
      end
      if (in_y_s && (h_s == H_TOTAL - 10'd1)) begin
        if (cur_sy_s == S_LAST) begin
          sy_r <= '0;
          cy_r <= cur_cy_s + CW'(1);
        end else begin
          sy_r <= cur_sy_s + SXW'(1);
          cy_r <= cur_cy_s;
        end
      end
    end
  end

  // Frame snapshot of the grid, taken at the start of vertical blanking.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_r        <= '0;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= snap_now_s;
      if (snap_now_s) begin
        snap_r <= grid_in;
      end
    end
  end

  // Stage 1: position classification and raw sync capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_board_s1_r <= 1'b0;
      visible_s1_r  <= 1'b0;
      cx_s1_r       <= '0;
      cy_s1_r       <= '0;
      hsync_s1_r    <= 1'b1;
      vsync_s1_r    <= 1'b1;
`ifdef GRID_LINES_EN
      border_s1_r   <= 1'b0;
`endif
    end else if (pix_en_s) begin
      in_board_s1_r <= in_x_s && in_y_s;
      visible_s1_r  <= visible_s;
      cx_s1_r       <= cur_cx_s;
      cy_s1_r       <= cur_cy_s;
      hsync_s1_r    <= hsync_raw_s;
      vsync_s1_r    <= vsync_raw_s;
`ifdef GRID_LINES_EN
      border_s1_r   <= (cur_sx_s == {SXW{1'b0}}) || (cur_sy_s == {SXW{1'b0}});
`endif
    end
  end

  // Stage 2 colour selection; snapshot bit index is col*16 + row.
  always_comb begin
    rgb_next_s = 12'h000;
    if (!visible_s1_r) begin
      rgb_next_s = 12'h000;
    end else if (!in_board_s1_r) begin
      rgb_next_s = BG_RGB;
`ifdef GRID_LINES_EN
    end else if (border_s1_r) begin
      rgb_next_s = LINE_RGB;
`endif
    end else if (snap_r[{cx_s1_r, cy_s1_r}]) begin
      rgb_next_s = FILL_RGB;
    end else begin
      rgb_next_s = EMPTY_RGB;
    end
  end

  // Stage 2 output registers, syncs kept aligned with the pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_r   <= 12'h000;
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
    end else if (pix_en_s) begin
      rgb_r   <= rgb_next_s;
      hsync_r <= hsync_s1_r;
      vsync_r <= vsync_s1_r;
    end
  end

  assign rgb         = rgb_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign frame_start = frame_start_r;

endmodule
